// File: rtl/demux_rr_sched.sv
// Round-robin scheduler driving a 1-to-4 demux from one valid/ready stream.
// Optional lane skipping is enabled with DEMUX_RR_SCHED_SKIP_EN.
module demux_rr_sched #(
    parameter int DWIDTH = 1,
    parameter int BURST  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [DWIDTH-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        lane_ready,
    output logic [DWIDTH-1:0] lane_data,
    output logic [3:0]        lane_valid,
    output logic [1:0]        sel,
    output logic [7:0]        skip_cnt
);

    // state | meaning
    // IDLE  | stopped, upstream held off, sel retained
    // RUN   | accepting items for lane sel while it is ready
    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    localparam logic [7:0] BURST_LAST = 8'(BURST - 1);

    state_t     state;
    logic [7:0] burst_cnt;
    logic       xfer;
    logic       skip;

    assign in_ready = (state == RUN) && enable && lane_ready[sel];
    assign xfer     = in_valid && in_ready;

`ifdef DEMUX_RR_SCHED_SKIP_EN
    assign skip = (state == RUN) && enable && in_valid && !lane_ready[sel];
`else
    assign skip = 1'b0;
    assign skip_cnt = 8'd0;
`endif

    // A transfer needs enable high, so it never shares an edge with the drop to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            sel        <= 2'd0;
            burst_cnt  <= 8'd0;
            lane_valid <= 4'd0;
            lane_data  <= '0;
`ifdef DEMUX_RR_SCHED_SKIP_EN
            skip_cnt   <= 8'd0;
`endif
        end else begin
            lane_valid <= 4'd0;
            if (xfer) begin
                lane_data  <= in_data;
                lane_valid <= 4'b0001 << sel;
            end

            case (state)
                IDLE: if (enable) state <= RUN;
                RUN:  if (!enable) state <= IDLE;
                default: state <= IDLE;
            endcase

            if (xfer && burst_cnt == BURST_LAST) begin
                burst_cnt <= 8'd0;
                sel       <= sel + 2'd1;
            end else if (xfer) begin
                burst_cnt <= burst_cnt + 8'd1;
            end else if (skip) begin
                burst_cnt <= 8'd0;
                sel       <= sel + 2'd1;
            end else if (state == RUN && !enable) begin
                burst_cnt <= 8'd0;
            end

`ifdef DEMUX_RR_SCHED_SKIP_EN
            if (skip && skip_cnt != 8'd255)
                skip_cnt <= skip_cnt + 8'd1;
`endif
        end
    end

endmodule

// File: tb/tb_demux_rr_sched.sv
// Bench for demux_rr_sched: three instances (BURST 4, 2, 1) on shared inputs,
// checked every cycle against a lane/burst-count model plus directed literals.
module tb_demux_rr_sched;

`ifdef DEMUX_RR_SCHED_SKIP_EN
    localparam bit SKIPEN = 1'b1;
`else
    localparam bit SKIPEN = 1'b0;
`endif
    localparam int NI = 3;
    localparam int BV [NI] = '{4, 2, 1};

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       enable = 1'b0;
    logic [3:0] in_data = 4'd0;
    logic       in_valid = 1'b0;
    logic [3:0] lane_ready = 4'd0;

    logic       ir [NI];
    logic [3:0] ld [NI];
    logic [3:0] lv [NI];
    logic [1:0] sl [NI];
    logic [7:0] sk [NI];

    demux_rr_sched #(.DWIDTH(4), .BURST(4)) dut0 (
        .clk(clk), .rst(rst), .enable(enable), .in_data(in_data), .in_valid(in_valid),
        .in_ready(ir[0]), .lane_ready(lane_ready), .lane_data(ld[0]), .lane_valid(lv[0]),
        .sel(sl[0]), .skip_cnt(sk[0]));
    demux_rr_sched #(.DWIDTH(4), .BURST(2)) dut1 (
        .clk(clk), .rst(rst), .enable(enable), .in_data(in_data), .in_valid(in_valid),
        .in_ready(ir[1]), .lane_ready(lane_ready), .lane_data(ld[1]), .lane_valid(lv[1]),
        .sel(sl[1]), .skip_cnt(sk[1]));
    demux_rr_sched #(.DWIDTH(4), .BURST(1)) dut2 (
        .clk(clk), .rst(rst), .enable(enable), .in_data(in_data), .in_valid(in_valid),
        .in_ready(ir[2]), .lane_ready(lane_ready), .lane_data(ld[2]), .lane_valid(lv[2]),
        .sel(sl[2]), .skip_cnt(sk[2]));

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    bit chk_on = 1'b0;

    // model: running flag, current lane, items sent in this burst, skips seen
    bit m_run  [NI];
    int m_lane [NI];
    int m_sent [NI];
    int m_skip [NI];
    int m_ld   [NI];
    int m_lv   [NI];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < NI; i++) begin
            if (rst) begin
                m_run[i] = 0; m_lane[i] = 0; m_sent[i] = 0;
                m_skip[i] = 0; m_ld[i] = 0; m_lv[i] = 0;
            end else begin
                bit acc;
                bit stalled;
                acc     = m_run[i] && enable && lane_ready[m_lane[i]] && in_valid;
                stalled = m_run[i] && enable && !lane_ready[m_lane[i]] && in_valid;
                m_lv[i] = 0;
                if (acc) begin
                    m_ld[i] = int'(in_data);
                    m_lv[i] = 1 << m_lane[i];
                    m_sent[i] = m_sent[i] + 1;
                    if (m_sent[i] == BV[i]) begin
                        m_sent[i] = 0;
                        m_lane[i] = (m_lane[i] + 1) % 4;
                    end
                end else if (stalled && SKIPEN) begin
                    m_lane[i] = (m_lane[i] + 1) % 4;
                    m_sent[i] = 0;
                    if (m_skip[i] < 255) m_skip[i] = m_skip[i] + 1;
                end
                if (m_run[i] && !enable) begin
                    m_run[i] = 0;
                    m_sent[i] = 0;
                end else if (!m_run[i] && enable) begin
                    m_run[i] = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < NI; i++) begin
                check($sformatf("m%0d.lane_valid", i), int'(lv[i]), m_lv[i]);
                check($sformatf("m%0d.lane_data", i), int'(ld[i]), m_ld[i]);
                check($sformatf("m%0d.sel", i), int'(sl[i]), m_lane[i]);
                check($sformatf("m%0d.skip_cnt", i), int'(sk[i]), m_skip[i]);
                check($sformatf("m%0d.in_ready", i), int'(ir[i]),
                      int'(m_run[i] && enable && lane_ready[m_lane[i]]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        enable = 0; in_valid = 0; lane_ready = 4'hF; in_data = 0;
        rst = 1;
        tick(); tick();
        rst = 0;
    endtask

    initial begin
        #2;
        do_reset();
        chk_on = 1'b1;
        check("rst.lane_valid", int'(lv[0]), 0);
        check("rst.sel", int'(sl[0]), 0);
        check("rst.in_ready", int'(ir[0]), 0);

        // full rotation with every lane ready
        enable = 1; in_valid = 1; lane_ready = 4'hF;
        tick();
        check("rot.in_ready", int'(ir[0]), 1);
        for (int k = 0; k < 16; k++) begin
            in_data = 4'(k);
            tick();
            check($sformatf("rot.b4.lv%0d", k), int'(lv[0]), 1 << (k / 4));
            check($sformatf("rot.b4.ld%0d", k), int'(ld[0]), k);
            check($sformatf("rot.b1.lv%0d", k), int'(lv[2]), 1 << (k % 4));
        end
        check("rot.sel_back", int'(sl[0]), 0);

        // lane 1 stalled, BURST=2 instance
        do_reset();
        lane_ready = 4'b1101; enable = 1; in_valid = 1; in_data = 4'd5;
        tick();
        tick();
        check("stall.lv_a", int'(lv[1]), 4'b0001);
        tick();
        check("stall.lv_b", int'(lv[1]), 4'b0001);
        check("stall.sel1", int'(sl[1]), 1);
        tick();
        check("stall.dead_lv", int'(lv[1]), 0);
        check("stall.skip_cnt", int'(sk[1]), SKIPEN ? 1 : 0);
        check("stall.sel_after", int'(sl[1]), SKIPEN ? 2 : 1);
        check("stall.in_ready", int'(ir[1]), SKIPEN ? 1 : 0);
        tick();
        check("stall.next_lv", int'(lv[1]), SKIPEN ? 4'b0100 : 4'b0000);
        lane_ready = 4'hF;
        #1;
        check("stall.ready_back", int'(ir[1]), 1);
        tick();
        check("stall.resume_lv", int'(lv[1]), SKIPEN ? 4'b0100 : 4'b0010);

        // enable dropped mid-burst on lane 1
        do_reset();
        enable = 1; in_valid = 1;
        tick();
        repeat (4) tick();
        repeat (2) begin
            tick();
            check("en.lane1_part", int'(lv[0]), 4'b0010);
        end
        enable = 0;
        #1;
        check("en.ready_drop", int'(ir[0]), 0);
        tick();
        check("en.idle_lv", int'(lv[0]), 0);
        check("en.idle_sel", int'(sl[0]), 1);
        enable = 1;
        tick();
        check("en.rerun_lv", int'(lv[0]), 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("en.fresh%0d", k), int'(lv[0]), 4'b0010);
        end
        tick();
        check("en.next_lane", int'(lv[0]), 4'b0100);

        // asynchronous reset mid-transfer
        in_data = 4'd9;
        repeat (3) tick();
        @(posedge clk);
        #3;
        rst = 1;
        #1;
        check("arst.lv", int'(lv[0]), 0);
        check("arst.ld", int'(ld[0]), 0);
        check("arst.sel", int'(sl[0]), 0);
        check("arst.in_ready", int'(ir[0]), 0);
        repeat (3) tick();
        rst = 0;
        tick();
        tick();
        check("arst.first_lane0", int'(lv[0]), 4'b0001);

        // saturating skip counter
        do_reset();
        enable = 1; in_valid = 1; lane_ready = 4'h0;
        repeat (301) tick();
        check("sat.skip_cnt", int'(sk[0]), SKIPEN ? 255 : 0);

        // randomized traffic
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            enable     = ($urandom % 10) != 0;
            in_valid   = ($urandom % 4) != 0;
            lane_ready = 4'($urandom | $urandom);
            in_data    = 4'($urandom);
            if ($urandom % 200 == 0) begin
                rst = 1;
                tick();
                rst = 0;
            end
            tick();
        end

        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/demux_rr_sched.md
# demux_rr_sched

Round-robin scheduler that drives a 1-to-4 demultiplexer from a single valid/ready input stream. It owns the 2-bit lane select, accepts items only when the selected lane can take them, and moves to the next lane after BURST items. Outputs are a registered data bus plus a one-hot per-lane valid strobe. It sits between the upstream serial source and the four downstream lane consumers.

## Interface
- DWIDTH, 1: width of each data item.
- BURST, 4: items sent to one lane before the select advances; legal range 1..255.
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- enable  input  1  run/stop control for the scheduler.
- in_data  input  DWIDTH  upstream item.
- in_valid  input  1  upstream item present.
- in_ready  output  1  upstream handshake; combinational.
- lane_ready  input  4  per-lane accept; bit n is lane n (lane 0 = A … lane 3 = D).
- lane_data  output  DWIDTH  registered item for the strobed lane.
- lane_valid  output  4  registered one-hot strobe, at most one bit high.
- sel  output  2  current lane pointer, registered.
- skip_cnt  output  8  saturating count of lane skips.

## Operation
- States: IDLE, RUN.
- IDLE: in_ready=0. Goes to RUN on the next edge when enable=1.
- RUN: in_ready = enable & lane_ready[sel]. Goes to IDLE on the next edge when enable=0. On that edge burst_cnt clears and sel holds.
- Transfer: a transfer occurs on an edge where in_valid & in_ready. On it:
  - lane_data <= in_data.
  - lane_valid <= 4'b0001 << sel.
  - burst_cnt increments.
- Burst end: when a transfer occurs with burst_cnt==BURST-1, burst_cnt <= 0 and sel <= sel+1 (mod 4, 3 wraps to 0).
- No transfer: lane_valid <= 0. lane_data holds its last value.
- Skip: in RUN with enable=1, in_valid=1 and lane_ready[sel]=0:
  - sel <= sel+1 on the next edge.
  - burst_cnt <= 0.
  - skip_cnt increments, saturating at 255.
  - No skip occurs when in_valid=0.
- burst_cnt is an internal 8-bit counter. It is never observable except through sel advance.

## Timing
- Reset values: state IDLE, sel 0, burst_cnt 0, lane_valid 0, lane_data 0, skip_cnt 0, in_ready 0.
- Reset mid-burst aborts immediately. An item accepted in the same cycle reset asserts is dropped.
- Latency: an item accepted on edge k appears on lane_data/lane_valid during the cycle after edge k. That is 1 cycle.
- Throughput: one item per cycle while lane_ready[sel]=1 and in_valid=1, including across lane advances. There is no bubble at a burst boundary.
- in_ready depends on lane_ready, enable and state only. It never depends on in_valid.
- lane_ready is sampled in the accept cycle only. Downstream must accept the strobe unconditionally.
- enable falling and a transfer in the same cycle: the transfer completes (in_ready was high), then IDLE is entered.
- BURST=1: sel advances after every transfer.

## Configuration
- DEMUX_RR_SCHED_SKIP_EN defined: skip behaviour as in Operation. A stalled lane is passed over and skip_cnt counts the skips.
- Not defined: strict round robin. The scheduler waits on a not-ready lane indefinitely. sel changes only at burst end. skip_cnt is tied to 0 and the port is kept.

## Test plan
- Reset then enable=1, in_valid=1, all lane_ready=1, BURST=4, 16 items 0..15 (DWIDTH=4) -> lane_valid strobes 0001×4, 0010×4, 0100×4, 1000×4. Items 0-3 go to lane 0, and so on. sel returns to 0. No idle cycles.
- lane_ready=4'b1101 with SKIP_EN, in_valid continuous, BURST=2 -> sequence lane0,lane0, one dead cycle (skip, skip_cnt=1), lane2,lane2, lane3,lane3, lane0…
- Same stimulus without SKIP_EN -> lane0 twice, then in_ready=0 and no strobes until lane_ready[1] rises. skip_cnt stays 0.
- enable dropped after 2 of 4 items on lane 1 -> IDLE, in_ready=0. Re-enable -> resumes on lane 1 with a fresh 4-item burst.
- rst asserted asynchronously mid-transfer, then held 3 cycles -> all outputs 0 immediately without waiting for a clock edge. The first post-reset item goes to lane 0.
- 300 skips forced via lane_ready=0 with in_valid=1 -> skip_cnt saturates at 255 and sel keeps cycling 0,1,2,3.
